data_mem_wbuf: RTL and testbench

//  Data-memory front end sitting directly downstream of the MIPS datapath: consumes adrDataMem /

---
 rtl/data_mem_wbuf.sv | 191 +++++++++++++++++++
 tb/tb_data_mem_wbuf.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_wbuf.sv
// data_mem_wbuf: data-memory front end for the MIPS datapath.
// Stores are posted into a DEPTH-entry FIFO write buffer and drained to a
// slow backing memory. Loads are served from the buffer or from memory.
// Optional feature macro: WBUF_FWD_EN (store-to-load forwarding). When it is
// not defined, a load that matches a buffered store waits for the buffer to
// drain and then reads memory, so memory order is preserved.
//
// Handshake (backing memory): mem_req rises with mem_we/mem_adr/mem_wdata and
// all four stay stable until the single-cycle mem_ack. The request completes
// at the clock edge that samples mem_ack=1. For a read, mem_rdata is valid in
// the same cycle as mem_ack. Only one request is outstanding, and the next one
// can start no earlier than the cycle after the ack.
module data_mem_wbuf #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             MemWrite,
  input  logic             MemRead,
  input  logic [31:0]      adrDataMem,
  input  logic [31:0]      WriteDataMem,
  output logic [31:0]      DataMemOut,
  output logic             stall,
  output logic             mem_req,
  output logic             mem_we,
  output logic [29:0]      mem_adr,
  output logic [31:0]      mem_wdata,
  input  logic             mem_ack,
  input  logic [31:0]      mem_rdata,
  output logic [1:0]       o_dbg_state,
  output logic [PTR_W:0]   o_dbg_count
);

  localparam logic [PTR_W:0]   C_DEPTH   = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   C_ONE_CNT = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] C_ONE_PTR = PTR_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

  state_t           r_state;
  logic [29:0]      r_adr [DEPTH];
  logic [31:0]      r_dat [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W:0]   r_count;

  logic [29:0]      w_word_adr;
  logic             w_full;
  logic             w_match;
  logic             w_load_hit;
  logic             w_rd_issue;
  logic             w_rd_ack;
  logic             w_enq;
  logic             w_deq;
  logic             w_unused;
`ifdef WBUF_FWD_EN
  logic [31:0]      w_fwd_data;
`endif

  // Word accesses only: the byte offset is intentionally dropped.
  assign w_word_adr = adrDataMem[31:2];
  assign w_unused   = ^adrDataMem[1:0];

  // Full is taken from the registered count, so a dequeue in the same cycle
  // does not let a store in; the store lands the following cycle.
  assign w_full = (r_count == C_DEPTH);

  // Scan valid entries oldest to youngest; the last hit is the youngest.
  always_comb begin
    w_match = 1'b0;
`ifdef WBUF_FWD_EN
    w_fwd_data = '0;
`endif
    for (int i = 0; i < DEPTH; i++) begin
      if (((PTR_W+1)'(i) < r_count) &&
          (r_adr[r_rd_ptr + PTR_W'(i)] == w_word_adr)) begin
        w_match = 1'b1;
`ifdef WBUF_FWD_EN
        w_fwd_data = r_dat[r_rd_ptr + PTR_W'(i)];
`endif
      end
    end
  end

`ifdef WBUF_FWD_EN
  assign w_load_hit = MemRead && w_match;
`else
  assign w_load_hit = 1'b0;
`endif

  // A load needs memory when no buffered store covers its word. With no
  // forwarding, a covered load waits here until the drain clears the match.
  assign w_rd_issue = MemRead && !w_match;
  assign w_rd_ack   = (r_state == ST_READ) && mem_ack;
  assign w_enq      = MemWrite && !w_full;
  assign w_deq      = (r_state == ST_WRITE) && mem_ack;

  assign stall = (MemWrite && w_full) ||
                 (MemRead && !w_load_hit && !w_rd_ack);

  // Load data: forwarded entry, else read data passed straight through on ack.
  always_comb begin
    DataMemOut = '0;
`ifdef WBUF_FWD_EN
    if (w_load_hit) begin
      DataMemOut = w_fwd_data;
    end else
`endif
    if (MemRead && w_rd_ack) begin
      DataMemOut = mem_rdata;
    end
  end

  // Buffer storage: contents need no reset, validity comes from the count.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_adr[r_wr_ptr] <= w_word_adr;
      r_dat[r_wr_ptr] <= WriteDataMem;
    end
  end

  // Buffer pointers and occupancy; simultaneous enq and deq leave count alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_enq) begin
        r_wr_ptr <= r_wr_ptr + C_ONE_PTR;
      end
      if (w_deq) begin
        r_rd_ptr <= r_rd_ptr + C_ONE_PTR;
      end
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + C_ONE_CNT;
        2'b01:   r_count <= r_count - C_ONE_CNT;
        default: r_count <= r_count;
      endcase
    end
  end

  // Memory port FSM: reads beat drains, one request in flight at a time.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_adr   <= '0;
      mem_wdata <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_rd_issue) begin
            r_state <= ST_READ;
            mem_req <= 1'b1;
            mem_we  <= 1'b0;
            mem_adr <= w_word_adr;
          end else if (r_count != '0) begin
            r_state   <= ST_WRITE;
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_adr   <= r_adr[r_rd_ptr];
            mem_wdata <= r_dat[r_rd_ptr];
          end
        end
        ST_READ, ST_WRITE: begin
          if (mem_ack) begin
            r_state <= ST_IDLE;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
        end
      endcase
    end
  end

  assign o_dbg_state = r_state;
  assign o_dbg_count = r_count;

endmodule

// File: tb/tb_data_mem_wbuf.sv
// tb_data_mem_wbuf: randomized and directed bench for data_mem_wbuf.
// Reference model: an architectural memory (last value stored to each word),
// a queue of posted-but-not-yet-written stores, and a backing-memory array
// updated when a write completes.
module tb_data_mem_wbuf;

  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

  // ---------------- clock / reset ----------------
  logic              clk = 1'b0;
  logic              rst;
  logic              MemWrite, MemRead;
  logic [31:0]       adrDataMem, WriteDataMem;
  logic [31:0]       DataMemOut;
  logic              stall;
  logic              mem_req, mem_we;
  logic [29:0]       mem_adr;
  logic [31:0]       mem_wdata;
  logic              mem_ack;
  logic [31:0]       mem_rdata;
  logic [1:0]        o_dbg_state;
  logic [PTR_W:0]    o_dbg_count;

  always #5 clk = ~clk;

  data_mem_wbuf #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk(clk), .rst(rst),
    .MemWrite(MemWrite), .MemRead(MemRead),
    .adrDataMem(adrDataMem), .WriteDataMem(WriteDataMem),
    .DataMemOut(DataMemOut), .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_adr(mem_adr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .o_dbg_state(o_dbg_state), .o_dbg_count(o_dbg_count)
  );

  // ---------------- scoreboard / model ----------------
  int n_checks = 0;
  int n_fail   = 0;

  logic [61:0] exp_q[$];                 // posted stores {word_adr, data}
  logic [31:0] arch[logic [29:0]];       // program-order memory image
  logic [31:0] mem_store[logic [29:0]];  // backing-memory image
  logic [29:0] cur_load_adr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_val(input logic [29:0] a);
    if (mem_store.exists(a)) return mem_store[a];
    return {a, 2'b11} ^ 32'hC3C3_0000;
  endfunction

  function automatic logic [31:0] arch_val(input logic [29:0] a);
    if (arch.exists(a)) return arch[a];
    return mem_val(a);
  endfunction

  function automatic bit q_has(input logic [29:0] a);
    foreach (exp_q[i]) if (exp_q[i][61:32] == a) return 1'b1;
    return 1'b0;
  endfunction

  // ---------------- backing-memory responder ----------------
  bit          resp_en = 1'b1;
  int          lat_min = 0, lat_max = 0;
  int          lat_cur, cnt;
  bit          req_active = 1'b0;
  bit          pend_pop = 1'b0;
  logic [30:0] req_ctl_q;
  logic [31:0] req_dat_q;

  always @(posedge clk) begin
    #1;
    if (resp_en) begin
      mem_ack = 1'b0;
      // The DUT consumed the write ack at this edge: retire the head.
      if (pend_pop) begin
        mem_store[exp_q[0][61:32]] = exp_q[0][31:0];
        void'(exp_q.pop_front());
        pend_pop = 1'b0;
      end
      if (!rst && mem_req) begin
        if (!req_active) begin
          req_active = 1'b1;
          req_ctl_q  = {mem_we, mem_adr};
          req_dat_q  = mem_wdata;
          lat_cur    = $urandom_range(lat_max, lat_min);
          cnt        = 0;
        end else begin
          check("req_hold_ctl", {1'b0, mem_we, mem_adr}, {1'b0, req_ctl_q});
          if (mem_we) check("req_hold_wdata", mem_wdata, req_dat_q);
        end
        if (cnt == lat_cur) begin
          mem_ack    = 1'b1;
          req_active = 1'b0;
          if (mem_we) begin
            if (exp_q.size() == 0) begin
              check("wr_unexpected", 32'd1, 32'd0);
            end else begin
              check("wr_adr", {2'b00, mem_adr}, {2'b00, exp_q[0][61:32]});
              check("wr_data", mem_wdata, exp_q[0][31:0]);
              pend_pop = 1'b1;
            end
          end else begin
            mem_rdata = mem_val(mem_adr);
            check("rd_adr", {2'b00, mem_adr}, {2'b00, cur_load_adr});
            check("rd_order", {31'd0, q_has(mem_adr)}, 32'd0);
          end
        end else begin
          cnt++;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset(input int n);
    rst = 1'b1;
    MemRead = 1'b0;
    MemWrite = 1'b0;
    exp_q.delete();
    pend_pop = 1'b0;
    req_active = 1'b0;
    arch = mem_store;  // posted stores are lost
    repeat (n) @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, output int n_stall);
    bit done = 1'b0;
    bit exp_st;
    n_stall = 0;
    MemWrite = 1'b1; MemRead = 1'b0; adrDataMem = a; WriteDataMem = d;
    for (int k = 0; k < 300 && !done; k++) begin
      @(negedge clk);
      exp_st = (exp_q.size() == DEPTH);
      check("st_stall", {31'd0, stall}, {31'd0, exp_st});
      check("st_count", {29'd0, o_dbg_count}, exp_q.size());
      if (!exp_st) begin
        done = 1'b1;
        exp_q.push_back({a[31:2], d});
        arch[a[31:2]] = d;
      end else begin
        n_stall++;
      end
      @(posedge clk); #2;
    end
    if (!done) check("st_timeout", 32'd1, 32'd0);
    MemWrite = 1'b0;
  endtask

  task automatic do_load(input logic [31:0] a);
    bit done = 1'b0;
    bit fwd_exp;
    logic [31:0] exp_d;
    MemRead = 1'b1; MemWrite = 1'b0; adrDataMem = a;
    cur_load_adr = a[31:2];
    exp_d = arch_val(a[31:2]);
`ifdef WBUF_FWD_EN
    fwd_exp = q_has(a[31:2]);
`else
    fwd_exp = 1'b0;
`endif
    for (int k = 0; k < 300 && !done; k++) begin
      @(negedge clk);
      if (k == 0 && fwd_exp) check("ld_fwd_nostall", {31'd0, stall}, 32'd0);
      if (!stall) begin
        done = 1'b1;
        check("ld_data", DataMemOut, exp_d);
        if (!fwd_exp) check("ld_via_ack", {31'd0, mem_ack && !mem_we}, 32'd1);
      end
      @(posedge clk); #2;
    end
    if (!done) check("ld_timeout", 32'd1, 32'd0);
    MemRead = 1'b0;
  endtask

  task automatic do_idle(input int n);
    MemRead = 1'b0; MemWrite = 1'b0;
    repeat (n) begin
      @(negedge clk);
      check("idle_stall", {31'd0, stall}, 32'd0);
      check("idle_dout", DataMemOut, 32'd0);
      @(posedge clk); #2;
    end
  endtask

  task automatic wait_drain();
    bit done = 1'b0;
    MemRead = 1'b0; MemWrite = 1'b0;
    for (int k = 0; k < 400 && !done; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !pend_pop && !req_active) done = 1'b1;
      @(posedge clk); #2;
    end
    @(negedge clk);
    check("drain_done", {31'd0, done}, 32'd1);
    check("drain_count", {29'd0, o_dbg_count}, 32'd0);
    check("drain_req", {31'd0, mem_req}, 32'd0);
    @(posedge clk); #2;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int ns;
    bit seen;
    rst = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
    adrDataMem = '0; WriteDataMem = '0; mem_ack = 1'b0; mem_rdata = '0;
    cur_load_adr = '0;
    @(posedge clk); #2;

    // 1: reset state
    do_reset(2);
    @(negedge clk);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_req", {31'd0, mem_req}, 32'd0);
    check("rst_we", {31'd0, mem_we}, 32'd0);
    check("rst_dout", DataMemOut, 32'd0);
    check("rst_count", {29'd0, o_dbg_count}, 32'd0);
    check("rst_state", {30'd0, o_dbg_state}, 32'd0);
    @(posedge clk); #2;

    // 2: single store, ack 3 cycles after the request
    lat_min = 3; lat_max = 3;
    do_store(32'h0000_0100, 32'hDEAD_BEEF, ns);
    check("t2_no_stall", ns, 32'd0);
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (mem_req) seen = 1'b1;
      else begin @(posedge clk); #2; end
    end
    check("t2_req", {31'd0, seen}, 32'd1);
    check("t2_we", {31'd0, mem_we}, 32'd1);
    check("t2_adr", {2'b00, mem_adr}, 32'h0000_0040);
    check("t2_wdata", mem_wdata, 32'hDEAD_BEEF);
    @(posedge clk); #2;
    wait_drain();

    // 3: five back-to-back stores against a very slow memory
    lat_min = 6; lat_max = 6;
    for (int i = 0; i < 5; i++) begin
      do_store(32'h0000_0400 + 32'(i * 4), 32'hA000_0000 + 32'(i), ns);
      if (i < 4) check("t3_no_stall", ns, 32'd0);
      else       check("t3_full_stall", {31'd0, ns > 0}, 32'd1);
    end
    wait_drain();

    // 4: two stores to one word, then a load of that word
    lat_min = 2; lat_max = 2;
    do_store(32'h0000_0200, 32'h0000_0011, ns);
    do_store(32'h0000_0200, 32'h0000_0022, ns);
    do_load(32'h0000_0200);
    wait_drain();

    // 5: load miss while a drain write is in flight
    lat_min = 3; lat_max = 3;
    mem_store[30'h0C0] = 32'h0000_0055;
    arch[30'h0C0] = 32'h0000_0055;
    do_store(32'h0000_0500, 32'h0000_0077, ns);
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(posedge clk); #2;
      if (mem_req && mem_we) seen = 1'b1;
    end
    check("t5_wr_inflight", {31'd0, seen}, 32'd1);
    do_load(32'h0000_0300);
    do_idle(2);
    wait_drain();

    // 6a: reset discards posted stores
    resp_en = 1'b0;
    mem_ack = 1'b0;
    do_store(32'h0000_0600, 32'h1234_5678, ns);
    do_store(32'h0000_0604, 32'h8765_4321, ns);
    @(posedge clk); #2;
    do_reset(1);
    @(negedge clk);
    check("t6_count", {29'd0, o_dbg_count}, 32'd0);
    check("t6_req_a", {31'd0, mem_req}, 32'd0);
    @(posedge clk); #2;

    // 6b: reset in the middle of a read, then a stale ack
    MemRead = 1'b1; adrDataMem = 32'h0000_0700;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (mem_req && !mem_we) seen = 1'b1;
      @(posedge clk); #2;
    end
    check("t6_rd_issued", {31'd0, seen}, 32'd1);
    do_reset(1);
    @(negedge clk);
    check("t6_req_b", {31'd0, mem_req}, 32'd0);
    check("t6_state", {30'd0, o_dbg_state}, 32'd0);
    check("t6_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #2;
    mem_ack = 1'b1;
    @(posedge clk); #2;
    mem_ack = 1'b0;
    @(negedge clk);
    check("t6_stale_req", {31'd0, mem_req}, 32'd0);
    check("t6_stale_state", {30'd0, o_dbg_state}, 32'd0);
    check("t6_stale_count", {29'd0, o_dbg_count}, 32'd0);
    @(posedge clk); #2;
    resp_en = 1'b1;
    lat_min = 0; lat_max = 2;
    do_load(32'h0000_0600);  // must see the backing value, not the lost store
    do_idle(1);

    // Random traffic over a small set of words, byte offsets included.
    lat_min = 0; lat_max = 3;
    for (int n = 0; n < 200; n++) begin
      int op;
      logic [31:0] a;
      op = $urandom_range(0, 9);
      a  = 32'h0000_0800 + ($urandom_range(0, 7) << 2) + $urandom_range(0, 3);
      if (op < 4)      do_store(a, $urandom, ns);
      else if (op < 8) do_load(a);
      else             do_idle(1);
    end
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
